// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
// The transmitter imports the same baud defaults so both ends of the link stay matched.
package uart_pkg;

  localparam int DEFAULT_CLK_HZ       = 50_000_000;
  localparam int DEFAULT_BAUD         = 9600;
  localparam int DEFAULT_CLKS_PER_BIT = DEFAULT_CLK_HZ / DEFAULT_BAUD;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period counter for the receiver.
// mid_tick marks the middle of a bit, full_tick marks the end of a whole bit period.
module bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic mid_tick,
  output logic full_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Wrapping on full_tick lets consecutive data bits be timed without a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || full_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign mid_tick  = (cnt == MID_CNT);
  assign full_tick = (cnt == FULL_CNT);

endmodule

// File: rtl/uart_rx.sv
// Asynchronous serial receiver (8N1 / 8E1) with a sticky byte-ready flag and error flags.
// Handshake: Rx_flag is held until a one-cycle Clear_Rx_flag; a commit in that same cycle wins.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 SerialIn,
  input  logic                 Clear_Rx_flag,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Rx_flag,
  output logic                 Frame_error,
  output logic                 Parity_error,
  output logic                 Overrun,
  output logic [2:0]           dbg_state
);

  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  rx_state_t state, state_next;

  logic                 sync1, rx;
  logic                 mid_tick, full_tick;
  logic                 timer_clr, shift_en, par_sample, commit;
  logic [DATA_BITS-1:0] shift;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 par_err;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (timer_clr),
    .mid_tick  (mid_tick),
    .full_tick (full_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (!rx) state_next = ST_START;
      ST_START:  if (mid_tick) state_next = rx ? ST_IDLE : ST_DATA;
      ST_DATA:   if (full_tick && bit_cnt == LAST_BIT)
                   state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (full_tick) state_next = ST_STOP;
      ST_STOP:   if (full_tick) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Timer restarts on every state change so each phase is timed from its own entry.
  always_comb begin
    timer_clr  = (state == ST_IDLE) || (state_next != state);
    shift_en   = (state == ST_DATA) && full_tick;
    par_sample = (state == ST_PARITY) && full_tick;
    commit     = (state == ST_STOP) && full_tick;
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1        <= 1'b1;
      rx           <= 1'b1;
      shift        <= '0;
      bit_cnt      <= '0;
      par_err      <= 1'b0;
      Rx_Data      <= '0;
      Rx_flag      <= 1'b0;
      Frame_error  <= 1'b0;
      Parity_error <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      sync1 <= SerialIn;
      rx    <= sync1;

      if (state == ST_START) begin
        bit_cnt <= '0;
        par_err <= 1'b0;
      end
      if (shift_en) begin
        shift   <= {rx, shift[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (par_sample) begin
        par_err <= (^shift) ^ rx;
      end

      if (commit) begin
        Rx_Data      <= shift;
        Rx_flag      <= 1'b1;
        Frame_error  <= !rx;
        Parity_error <= par_err;
        // A clear in the commit cycle means the previous byte was consumed.
        Overrun      <= Clear_Rx_flag ? 1'b0 : (Overrun | Rx_flag);
      end else if (Clear_Rx_flag) begin
        Rx_flag      <= 1'b0;
        Frame_error  <= 1'b0;
        Parity_error <= 1'b0;
        Overrun      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: two instances at 16 clocks per bit, one without and one with even parity.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic       line0, line1;
  logic       clr0, clr1;
  logic [7:0] data0, data1;
  logic       flag0, flag1, fe0, fe1, pe0, pe1, ov0, ov1;
  logic [2:0] st0, st1;

  int checks = 0;
  int errors = 0;
  int rise;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(0)) dut0 (
    .clk (clk), .reset (rst0), .SerialIn (line0), .Clear_Rx_flag (clr0),
    .Rx_Data (data0), .Rx_flag (flag0), .Frame_error (fe0),
    .Parity_error (pe0), .Overrun (ov0), .dbg_state (st0)
  );

  uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1)) dut1 (
    .clk (clk), .reset (rst1), .SerialIn (line1), .Clear_Rx_flag (clr1),
    .Rx_Data (data1), .Rx_flag (flag1), .Frame_error (fe1),
    .Parity_error (pe1), .Overrun (ov1), .dbg_state (st1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame starting at a negedge; each bit lasts 16 cycles.
  // clr_k: iteration whose following posedge sees Clear_Rx_flag=1 (-1 for none).
  // stop_k: abandon the frame after this many cycles.
  // rise_k: first iteration at which the selected Rx_flag reads 1.
  task automatic send_frame(input logic [7:0] d, input logic which, input logic par_on,
                            input logic par_bit, input logic stop_bit, input int clr_k,
                            input int stop_k, output int rise_k);
    logic [11:0] fb;
    int          nbits;
    logic        cur;
    if (par_on) begin
      fb    = {1'b1, stop_bit, par_bit, d, 1'b0};
      nbits = 11;
    end else begin
      fb    = {2'b11, stop_bit, d, 1'b0};
      nbits = 10;
    end
    rise_k = -1;
    for (int k = 0; k < nbits * 16 && k < stop_k; k++) begin
      cur = which ? flag1 : flag0;
      if (rise_k < 0 && cur) rise_k = k;
      if (which) begin
        line1 = fb[k / 16];
        clr1  = (k == clr_k);
      end else begin
        line0 = fb[k / 16];
        clr0  = (k == clr_k);
      end
      @(negedge clk);
    end
    if (which) begin
      line1 = 1'b1;
      clr1  = 1'b0;
    end else begin
      line0 = 1'b1;
      clr0  = 1'b0;
    end
  endtask

  task automatic pulse_clear0();
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0;
    line0 = 1'b1; line1 = 1'b1;
    clr0 = 1'b0; clr1 = 1'b0;
    idle(3);
    check("rst_data", data0, 8'h00);
    check("rst_flag", flag0, 1'b0);
    check("rst_fe", fe0, 1'b0);
    check("rst_pe", pe0, 1'b0);
    check("rst_ov", ov0, 1'b0);
    check("rst_state", st0, 3'd0);
    rst0 = 1'b1; rst1 = 1'b1;
    idle(4);

    // Glitch: 4 low cycles reach START but are rejected at mid-bit.
    line0 = 1'b0;
    idle(4);
    check("glitch_in_start", st0, 3'd1);
    line0 = 1'b1;
    idle(30);
    check("glitch_state", st0, 3'd0);
    check("glitch_flag", flag0, 1'b0);
    check("glitch_data", data0, 8'h00);

    // 0xA5 8N1; latency counted in edges after the first edge that samples the low pin.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1000, rise);
    check("a5_latency", rise - 1, 154);
    check("a5_data", data0, 8'hA5);
    check("a5_flag", flag0, 1'b1);
    check("a5_fe", fe0, 1'b0);
    check("a5_pe", pe0, 1'b0);
    check("a5_ov", ov0, 1'b0);
    idle(20);
    pulse_clear0();
    check("a5_cleared", flag0, 1'b0);

    // 0x3C with a low stop bit.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1000, rise);
    idle(20);
    check("fe_data", data0, 8'h3C);
    check("fe_flag", flag0, 1'b1);
    check("fe_fe", fe0, 1'b1);
    check("fe_ov", ov0, 1'b0);
    pulse_clear0();
    check("fe_clr_flag", flag0, 1'b0);
    check("fe_clr_fe", fe0, 1'b0);
    check("fe_clr_data", data0, 8'h3C);

    // Overrun: two frames without a clear.
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1000, rise);
    idle(20);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1000, rise);
    idle(20);
    check("ov_data", data0, 8'h22);
    check("ov_flag", flag0, 1'b1);
    check("ov_ov", ov0, 1'b1);
    check("ov_fe", fe0, 1'b0);

    // Same pair, clear lands on the 0x22 commit edge (posedge 155 of the frame).
    pulse_clear0();
    check("ov_cleared", ov0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1000, rise);
    idle(20);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 154, 1000, rise);
    idle(20);
    check("clrc_data", data0, 8'h22);
    check("clrc_flag", flag0, 1'b1);
    check("clrc_ov", ov0, 1'b0);

    // Even parity: 0x07 has three ones, so the correct parity bit is 1.
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1000, rise);
    idle(20);
    check("par_latency", rise - 1, 170);
    check("par_bad_pe", pe1, 1'b1);
    check("par_bad_data", data1, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1000, rise);
    idle(20);
    check("par_ok_pe", pe1, 1'b0);
    check("par_ok_data", data1, 8'h07);
    check("par_ok_flag", flag1, 1'b1);
    check("par_ok_fe", fe1, 1'b0);

    // Reset in the middle of data bit 3 of 0xFF.
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, -1, 72, rise);
    rst0  = 1'b0;
    line0 = 1'b1;
    @(negedge clk);
    check("mid_rst_data", data0, 8'h00);
    check("mid_rst_flag", flag0, 1'b0);
    check("mid_rst_fe", fe0, 1'b0);
    check("mid_rst_pe", pe0, 1'b0);
    check("mid_rst_ov", ov0, 1'b0);
    check("mid_rst_state", st0, 3'd0);
    rst0 = 1'b1;
    idle(5);

    // Clear pulse mid-frame must not disturb reception.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 80, 1000, rise);
    idle(20);
    check("post_rst_data", data0, 8'h5A);
    check("post_rst_flag", flag0, 1'b1);
    check("post_rst_fe", fe0, 1'b0);
    check("post_rst_pe", pe0, 1'b0);
    check("post_rst_ov", ov0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver paired with the core's `SerialOut` transmit path. It gives the MIPS system a host-to-core serial link.
- Deserialises an 8N1 (optionally 8E1) asynchronous frame from `SerialIn` and presents the byte on a parallel register.
- A sticky ready flag is held until the consumer acknowledges with a clear pulse.
- Sits beside the core and is read as a memory-mapped peripheral through `I_D_Memory`-side glue.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per serial bit (50 MHz / 9600 baud); must be ≥ 4.
- DATA_BITS, 8, payload bits per frame, sent LSB first.
- PARITY_EN, 0, 1 = even parity bit expected between the data bits and the stop bit.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- SerialIn  input  1  asynchronous serial line; idles high.
- Clear_Rx_flag  input  1  one-cycle pulse; clears Rx_flag and all error flags.
- Rx_Data  output  DATA_BITS  last received byte.
- Rx_flag  output  1  byte available; sticky.
- Frame_error  output  1  last frame's stop bit sampled 0.
- Parity_error  output  1  last frame's parity mismatch (always 0 when PARITY_EN=0).
- Overrun  output  1  a frame completed while Rx_flag was still 1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; bit counter and clock counter = 0.
  - Synchroniser flops = 1.
  - Rx_Data=0, Rx_flag=0, Frame_error=0, Parity_error=0, Overrun=0.
  - Asserting reset mid-frame aborts the frame; no partial data is loaded.
- Input synchroniser: SerialIn passes through 2 flops before any use; the FSM sees the line 2 cycles late.
- Clock counter width is $clog2(CLKS_PER_BIT).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Synced line = 0 → START, clock counter cleared.
- START:
  - Count to CLKS_PER_BIT/2 − 1 (mid-bit).
  - Line still 0 → DATA, counters cleared.
  - Line = 1 → glitch rejected, back to IDLE; no flags change.
- DATA:
  - Every CLKS_PER_BIT cycles, sample the line and shift it in at the MSB of the shift register (LSB-first reception).
  - After DATA_BITS samples → PARITY if PARITY_EN=1, else STOP.
- PARITY:
  - Sample after CLKS_PER_BIT cycles.
  - parity_err = (XOR of data bits) XOR sampled bit; any result ≠ 0 is an error (even parity).
  - → STOP.
- STOP:
  - Sample after CLKS_PER_BIT cycles; this is the commit edge. On it:
    - Rx_Data ← shift register.
    - Rx_flag ← 1.
    - Frame_error ← (sample == 0).
    - Parity_error ← parity_err.
    - Overrun ← Overrun | Rx_flag (the old value).
  - Then → IDLE. A new start edge is accepted from the next cycle onward.
- Frames with errors are still loaded and flagged; software discards them.
- Overrun: the new byte overwrites Rx_Data. Overrun stays 1 until Clear_Rx_flag.
- Clear_Rx_flag with no commit that cycle: Rx_flag, Frame_error, Parity_error, Overrun ← 0 on the next edge.
- Clear_Rx_flag on the same cycle as a commit: the commit wins.
  - Rx_flag=1; error flags take the new frame's values.
  - Overrun=0, because the previous byte was consumed.
- Latency, from the first synced low sample to Rx_flag=1:
  - (CLKS_PER_BIT/2) + (DATA_BITS + PARITY_EN + 1)·CLKS_PER_BIT cycles.
  - Add 2 cycles when measured from the SerialIn pin.
- Clear_Rx_flag while the FSM is mid-frame does not disturb reception.
- All outputs are registered; there is no combinational path from SerialIn to any output.

Decomposition:
- Shared package `uart_pkg`:
  - State encoding localparams (IDLE, START, DATA, PARITY, STOP).
  - Default CLKS_PER_BIT / baud constants, reused by the transmitter so both ends stay matched.
- One natural sub-module, `bit_timer`: a clock counter with a `mid_tick` output (CLKS_PER_BIT/2 − 1) and a `full_tick` output (CLKS_PER_BIT − 1), plus a synchronous clear.
- The 2-flop synchroniser stays inline.

Test Plan:
- All scenarios use CLKS_PER_BIT=16 and DATA_BITS=8.
1. PARITY_EN=0, drive 0xA5 as 8N1 → Rx_Data=0xA5 and Rx_flag=1 exactly 8+144+2=154 cycles after SerialIn falls; Frame_error=Parity_error=Overrun=0.
2. Glitch: SerialIn low for 4 cycles, then high → FSM returns to IDLE; Rx_flag stays 0 and Rx_Data stays 0x00.
3. Send 0x3C with the stop bit driven 0 → Rx_Data=0x3C, Rx_flag=1, Frame_error=1; then pulse Clear_Rx_flag → all flags 0 next cycle.
4. Send 0x11 then 0x22 with no clear → Rx_Data=0x22, Rx_flag=1, Overrun=1. Repeat with Clear_Rx_flag pulsed on the 0x22 commit cycle → Overrun=0, Rx_flag=1.
5. PARITY_EN=1:
   - 0x07 with parity bit 0 → Parity_error=1.
   - 0x07 with parity bit 1 → Parity_error=0, Rx_Data=0x07.
6. Drop reset during data bit 3 of 0xFF, release it, then send 0x5A → outputs all 0 during reset; Rx_Data=0x5A and no error flags afterward.
